// File: rtl/dec_bank_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one decoder bank among four requesters.
// Latency: a request sampled in IDLE shows up as gnt after the next clk edge.
// Backpressure: requesters hold req until served; each grant lasts MAX_HOLD cycles at most.
//
// Ports:
//   clk       - single clock, rising-edge state updates
//   rst_n     - asynchronous active-low reset; clears every output immediately
//   en        - global enable; low blocks new grants and drops the current one
//   req[3:0]  - level request per requester, held while the bank is wanted
//   gnt[3:0]  - registered one-hot grant, drives the second-level decoder enables
//   gnt_idx   - registered binary owner index, drives the first-level decoder selects;
//               keeps its last value while no grant is active
//   gnt_valid - registered, equals |gnt
//   timeout   - registered one-cycle pulse after a forced release at MAX_HOLD
//
// MAX_HOLD must lie in 1..255 and fit in CW bits (2^CW > MAX_HOLD).

module dec_bank_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  // Rotating priority scan: first asserted request at ptr, ptr+1, ptr+2, ptr+3.
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
        if (en && sel_found) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << sel_idx;
          gnt_idx_d   = sel_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = CW'(1);
        end
      end

      GRANT: begin
        if (!en) begin
          // Disable keeps the pointer so the same owner can resume first.
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
        end else if (!req[gnt_idx_q]) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          ptr_d       = gnt_idx_q + 2'd1;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          // Forced release: owner drops to lowest priority for the next scan.
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          ptr_d       = gnt_idx_q + 2'd1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_dec_bank_rr_arbiter.sv
// Bench for dec_bank_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=1.
// Directed table, hand-written multi-cycle sequences and randomized traffic.
// Every cycle both instances are compared against a behavioural model.

module tb_dec_bank_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [3:0] req_a = 4'b0, req_b = 4'b0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b, to_a, to_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_bank_rr_arbiter #(.MAX_HOLD(8), .CW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a)
  );

  dec_bank_rr_arbiter #(.MAX_HOLD(1), .CW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b)
  );

  // ---------------- behavioural model ----------------
  // owner = -1 means nobody holds the bank.
  int m_owner [2];
  int m_held  [2];
  int m_next  [2];
  int m_last  [2];
  bit m_to    [2];
  int m_max   [2] = '{8, 1};

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1; m_held[u] = 0; m_next[u] = 0; m_last[u] = 0; m_to[u] = 1'b0;
    end
  endfunction

  function automatic void model_step(int u, bit e, logic [3:0] r);
    if (m_owner[u] < 0) begin
      m_to[u] = 1'b0;
      if (e && r != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner[u] < 0 && r[(m_next[u] + k) % 4]) begin
            m_owner[u] = (m_next[u] + k) % 4;
            m_last[u]  = m_owner[u];
            m_held[u]  = 1;
          end
        end
      end
    end else if (!e) begin
      m_owner[u] = -1;
      m_to[u]    = 1'b0;
    end else if (!r[m_owner[u]]) begin
      m_next[u]  = (m_owner[u] + 1) % 4;
      m_owner[u] = -1;
      m_to[u]    = 1'b0;
    end else if (m_held[u] == m_max[u]) begin
      m_next[u]  = (m_owner[u] + 1) % 4;
      m_owner[u] = -1;
      m_to[u]    = 1'b1;
    end else begin
      m_held[u] = m_held[u] + 1;
    end
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int eg_a, eg_b;
    eg_a = (m_owner[0] >= 0) ? (1 << m_owner[0]) : 0;
    eg_b = (m_owner[1] >= 0) ? (1 << m_owner[1]) : 0;
    cmp("model_a_gnt", int'(gnt_a), eg_a);
    cmp("model_a_idx", int'(idx_a), m_last[0]);
    cmp("model_a_vld", int'(vld_a), int'(m_owner[0] >= 0));
    cmp("model_a_to",  int'(to_a),  int'(m_to[0]));
    cmp("model_b_gnt", int'(gnt_b), eg_b);
    cmp("model_b_idx", int'(idx_b), m_last[1]);
    cmp("model_b_vld", int'(vld_b), int'(m_owner[1] >= 0));
    cmp("model_b_to",  int'(to_b),  int'(m_to[1]));
  endtask

  // One clock: model consumes the inputs sampled at the edge, then compare 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, en_a, req_a);
      model_step(1, en_b, req_b);
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Grant must never be multi-hot and valid must track |gnt.
  always @(negedge clk) begin
    checks++;
    chk_onehot: assert ($onehot0(gnt_a) && $onehot0(gnt_b) &&
                        vld_a == |gnt_a && vld_b == |gnt_b)
    else begin
      failures++;
      $display("FAIL onehot: gnt_a=%b vld_a=%b gnt_b=%b vld_b=%b required one-hot-or-zero and vld=|gnt",
               gnt_a, vld_a, gnt_b, vld_b);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl [19];

  initial begin
    tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // single request
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // release -> ptr 3
    tbl[2]  = '{1'b1, 4'b1100, 4'b1000, 2'd3, 1'b1, 1'b0}; // ptr 3 wins over 2
    tbl[3]  = '{1'b1, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0}; // release -> ptr 0
    tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // ptr 1
    tbl[6]  = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0}; // rotation skip to 3
    tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0}; // ptr 0
    tbl[8]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}; // then 0
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // ptr 1
    tbl[10] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0}; // ptr 2
    tbl[12] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // cnt 1
    tbl[13] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // cnt 2
    tbl[14] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // cnt 3
    tbl[15] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0}; // enable drop, no timeout
    tbl[16] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0}; // stays idle
    tbl[17] = '{1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0}; // ptr still 2
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #3;
    cmp("reset_gnt", int'(gnt_a), 0);
    cmp("reset_idx", int'(idx_a), 0);
    cmp("reset_vld", int'(vld_a), 0);
    cmp("reset_to",  int'(to_a),  0);
    do_reset();

    // Directed table on instance A (B idles with no request).
    en_b = 1'b1; req_b = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      en_a  = tbl[i].en;
      req_a = tbl[i].req;
      tick();
      cmp($sformatf("tbl%0d_gnt", i), int'(gnt_a), int'(tbl[i].gnt));
      cmp($sformatf("tbl%0d_idx", i), int'(idx_a), int'(tbl[i].idx));
      cmp($sformatf("tbl%0d_vld", i), int'(vld_a), int'(tbl[i].vld));
      cmp($sformatf("tbl%0d_to",  i), int'(to_a),  int'(tbl[i].to));
    end

    // Fairness: all four requesting, order 0,1,2,3,0, 8 cycles each then a timeout bubble.
    do_reset();
    en_a = 1'b1; req_a = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        cmp($sformatf("fair_g%0d_c%0d_gnt", g, c), int'(gnt_a), 1 << (g % 4));
        cmp($sformatf("fair_g%0d_c%0d_idx", g, c), int'(idx_a), g % 4);
        cmp($sformatf("fair_g%0d_c%0d_to", g, c), int'(to_a), 0);
      end
      tick();
      cmp($sformatf("fair_g%0d_bubble_gnt", g), int'(gnt_a), 0);
      cmp($sformatf("fair_g%0d_bubble_to", g), int'(to_a), 1);
    end

    // Async reset mid-grant.
    do_reset();
    en_a = 1'b1; req_a = 4'b0010;
    repeat (3) tick();
    cmp("areset_pre_gnt", int'(gnt_a), 4'b0010);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("areset_gnt", int'(gnt_a), 0);
    cmp("areset_vld", int'(vld_a), 0);
    cmp("areset_to",  int'(to_a),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_a = 4'b0011;
    tick();
    cmp("areset_first_gnt", int'(gnt_a), 4'b0001);
    cmp("areset_first_idx", int'(idx_a), 0);

    // MAX_HOLD=1 boundary on instance B.
    do_reset();
    en_a = 1'b0; req_a = 4'b0000;
    en_b = 1'b1; req_b = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      cmp($sformatf("mh1_c%0d_gnt", c), int'(gnt_b), (c % 2 == 0) ? 1 : 0);
      cmp($sformatf("mh1_c%0d_to", c), int'(to_b), (c % 2 == 0) ? 0 : 1);
    end

    // Randomized traffic on both instances, checked every cycle by the model.
    do_reset();
    en_a = 1'b1; en_b = 1'b1; req_a = 4'b0; req_b = 4'b0;
    for (int n = 0; n < 3000; n++) begin
      en_a = ($urandom_range(0, 19) != 0);
      en_b = ($urandom_range(0, 19) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) req_a[b] = ~req_a[b];
        if ($urandom_range(0, 5) == 0)  req_b[b] = ~req_b[b];
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_bank_rr_arbiter.md
# dec_bank_rr_arbiter

Round-robin arbiter that shares one decoder bank among four requesters. It grants exactly one requester at a time, with fair rotation and a bounded hold time. The one-hot grant drives the enable inputs of the four second-level 2x4 decoders directly, so at most one decoder is ever enabled. The encoded grant index drives the select inputs of the first-level decoder.

## Interface
Parameters:
- MAX_HOLD, 8, maximum cycles one requester may hold a grant; legal range 1..255.
- CW, 8, hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- en, input, 1, global arbiter enable; when low, no new grant is issued and any current grant is released.
- req, input, 4, request vector; req[i] is held high by requester i for as long as it wants the bank.
- gnt, output, 4, registered one-hot grant; all zeros when no grant is active.
- gnt_idx, output, 2, registered binary index of the granted requester; holds its last value when gnt_valid=0.
- gnt_valid, output, 1, registered; equals |gnt.
- timeout, output, 1, registered one-cycle pulse that marks a forced release at MAX_HOLD.

## Operation
- State: FSM {IDLE, GRANT}, 2-bit rotation pointer ptr, and hold counter cnt[CW-1:0].
- Reset values: state=IDLE, ptr=0, cnt=0, gnt=4'b0000, gnt_idx=0, gnt_valid=0, timeout=0.
- IDLE, with en=1 and req≠0:
  - Select the first asserted requester, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, cnt=1, state=GRANT.
- IDLE, with en=0 or req=0: stay in IDLE; outputs stay deasserted.
- GRANT, the owner is gnt_idx. Evaluate these conditions in priority order each cycle:
  1. en=0: next edge → IDLE, gnt=0, ptr unchanged, timeout=0.
  2. req[gnt_idx]=0 (voluntary release): next edge → IDLE, gnt=0, ptr=gnt_idx+1 mod 4.
  3. cnt==MAX_HOLD with req[gnt_idx] still 1 (forced release): next edge → IDLE, gnt=0, ptr=gnt_idx+1 mod 4, timeout=1 for one cycle.
  4. Otherwise: hold the grant and increment cnt. cnt never exceeds MAX_HOLD.
- Requests from non-owners are ignored while in GRANT. They are evaluated in the next IDLE cycle.
- A released owner that keeps req high is a normal requester in the next IDLE cycle. Because ptr has already advanced past it, it has the lowest priority.
- The ptr wrap 3→0 is mod-4 arithmetic.
- gnt is never multi-hot, in any cycle, under any input sequence.

## Timing
- Grant latency: req is sampled in IDLE at edge k; gnt is visible after edge k.
- Release: gnt drops at the edge after the release condition is sampled. Every release is followed by at least one IDLE cycle with gnt=0, which is the bank-switch bubble.
- Maximum grant length: MAX_HOLD consecutive cycles with gnt_valid=1.
- timeout is high only in the first IDLE cycle after a forced release. It is 0 in every other cycle.
- Reset mid-grant: when rst_n falls, all outputs clear immediately, without waiting for a clock edge. The first grant after reset begins its scan at requester 0.
- Worst-case wait: with all four requesters active, a requester waits at most 3·(MAX_HOLD+1) cycles for a grant.
- Inputs are synchronous to clk. The block performs no input synchronization.

## Test plan
- Reset then single request:
  - Stimulus: rst_n low for 2 cycles, release, then req=4'b0100, en=1.
  - Required: gnt=4'b0100 and gnt_idx=2 after the first edge. When req drops, gnt=0 after the next edge and ptr=3.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, MAX_HOLD=8.
  - Required: grant order 0,1,2,3,0; each grant lasts exactly 8 cycles, followed by 1 idle cycle with timeout=1.
- Rotation skip:
  - Stimulus: ptr=1 after releasing requester 0, then req=4'b1001.
  - Required: requester 3 is granted (gnt_idx=3), then requester 0.
- Enable drop mid-grant:
  - Stimulus: requester 2 granted, en=0 at cnt=3.
  - Required: gnt=0 after the next edge, timeout=0, ptr unchanged (=2). With en=1 again, requester 2 is granted again if it is still requesting.
- Async reset mid-grant:
  - Stimulus: requester 1 granted, rst_n pulsed low between clock edges.
  - Required: gnt=0, gnt_valid=0, timeout=0 immediately. With req=4'b0011 after reset, requester 0 is granted first.
- Boundary MAX_HOLD=1:
  - Stimulus: req=4'b0001 held.
  - Required: the pattern gnt=4'b0001 for 1 cycle, then 0 with timeout=1, repeats continuously. gnt is never multi-hot (check with an assertion every cycle).
